// File: rtl/game_pkg.sv
// Shared game-logic types and sprite sizes used by the collision stage and
// the draw_character / draw_barrel instantiations.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        INVULN    = 2'd2,
        GAME_OVER = 2'd3
    } collision_state_t;

    localparam int DONKEY_W = 48;
    localparam int DONKEY_H = 64;
    localparam int BARREL_W = 32;
    localparam int BARREL_H = 32;

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned bounding-box overlap test between box A and box B.
// Edge-touching boxes do not count as overlapping.
module box_overlap #(
    parameter int A_W = 48,
    parameter int A_H = 64,
    parameter int B_W = 32,
    parameter int B_H = 32
) (
    input  logic [10:0] xa,
    input  logic [10:0] ya,
    input  logic [10:0] xb,
    input  logic [10:0] yb,
    output logic        overlap
);

    // Sums are widened to 12 bits so positions near 2047 never wrap.
    logic [11:0] xa_s, ya_s, xb_s, yb_s;

    // Widen positions and evaluate the four strict inequalities.
    always_comb begin
        xa_s    = {1'b0, xa};
        ya_s    = {1'b0, ya};
        xb_s    = {1'b0, xb};
        yb_s    = {1'b0, yb};
        overlap = (xa_s < (xb_s + 12'(B_W))) &&
                  (xb_s < (xa_s + 12'(A_W))) &&
                  (ya_s < (yb_s + 12'(B_H))) &&
                  (yb_s < (ya_s + 12'(A_H)));
    end

endmodule

// File: rtl/barrel_collision_ctl.sv
// Sequential Donkey-vs-barrel collision scanner with lives counter and
// play / invulnerable / game-over state machine.
module barrel_collision_ctl #(
    parameter int BARRELS     = 10,
    parameter int LIVES       = 3,
    parameter int DONKEY_W    = game_pkg::DONKEY_W,
    parameter int DONKEY_H    = game_pkg::DONKEY_H,
    parameter int BARREL_W    = game_pkg::BARREL_W,
    parameter int BARREL_H    = game_pkg::BARREL_H,
    parameter int INVULN_TIME = 65_000_000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_game,
    input  logic                             animation,
    input  logic [10:0]                      xpos_donkey,
    input  logic [10:0]                      ypos_donkey,
    input  logic [BARRELS-1:0][10:0]         xpos_barrel,
    input  logic [BARRELS-1:0][10:0]         ypos_barrel,
    input  logic [BARRELS-1:0]               barrel,
    output logic                             hit,
    output logic [$clog2(LIVES+1)-1:0]       lives,
    output logic                             freeze,
    output logic                             game_over
);

    import game_pkg::*;

    localparam int IW = (BARRELS > 1) ? $clog2(BARRELS) : 1;
    localparam int LW = $clog2(LIVES + 1);
    localparam int CW = (INVULN_TIME > 1) ? $clog2(INVULN_TIME) : 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(BARRELS - 1);
    localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);
    localparam logic [CW-1:0] CNT_LOAD   = CW'(INVULN_TIME - 1);

    collision_state_t state_r, state_s;
    logic [IW-1:0]    scan_idx_r;
    logic [10:0]      xb_s, yb_s;
    logic             box_hit_s, ovl_s, ovl_r, last_r, sweep_r, sample_s;
    logic             clear_sweep_s;
    logic [LW-1:0]    lives_r, lives_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             hit_r, hit_s, freeze_r, freeze_s, game_over_r, game_over_s;

    // Select the barrel slot currently under test.
    always_comb begin
        xb_s     = xpos_barrel[scan_idx_r];
        yb_s     = ypos_barrel[scan_idx_r];
        ovl_s    = barrel[scan_idx_r] & box_hit_s;
        sample_s = last_r & (sweep_r | ovl_r);
    end

    box_overlap #(
        .A_W (DONKEY_W),
        .A_H (DONKEY_H),
        .B_W (BARREL_W),
        .B_H (BARREL_H)
    ) u_box_overlap (
        .xa      (xpos_donkey),
        .ya      (ypos_donkey),
        .xb      (xb_s),
        .yb      (yb_s),
        .overlap (box_hit_s)
    );

    // Scanner: walk the slots, register each result, OR them into a sweep flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx_r <= '0;
            ovl_r      <= 1'b0;
            last_r     <= 1'b0;
            sweep_r    <= 1'b0;
        end else begin
            scan_idx_r <= (scan_idx_r == LAST_IDX) ? IW'(0) : scan_idx_r + IW'(1);
            ovl_r      <= ovl_s;
            last_r     <= (scan_idx_r == LAST_IDX);
            // Flag is consumed at end of sweep; leaving INVULN drops stale hits.
            if (last_r || clear_sweep_s) begin
                sweep_r <= 1'b0;
            end else begin
                sweep_r <= sweep_r | ovl_r;
            end
        end
    end

    // Next-state, lives, cooldown and output decode.
    always_comb begin
        state_s       = state_r;
        lives_s       = lives_r;
        cnt_s         = cnt_r;
        hit_s         = 1'b0;
        clear_sweep_s = 1'b0;
        case (state_r)
            IDLE: begin
                lives_s = LIVES_INIT;
                cnt_s   = '0;
                if (start_game && !animation) begin
                    state_s = PLAY;
                end else begin
                    state_s = IDLE;
                end
            end
            PLAY: begin
                if (!start_game || animation) begin
                    state_s = IDLE;
                    lives_s = LIVES_INIT;
                end else if (sample_s && (lives_r != LW'(0))) begin
                    hit_s   = 1'b1;
                    lives_s = lives_r - LW'(1);
                    if (lives_r == LW'(1)) begin
                        state_s = GAME_OVER;
                    end else begin
                        state_s = INVULN;
                        cnt_s   = CNT_LOAD;
                    end
                end else begin
                    state_s = PLAY;
                end
            end
            INVULN: begin
                if (!start_game) begin
                    state_s = IDLE;
                    lives_s = LIVES_INIT;
                    cnt_s   = '0;
                end else if (cnt_r == CW'(0)) begin
                    state_s       = PLAY;
                    clear_sweep_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            GAME_OVER: begin
                state_s = GAME_OVER;
                lives_s = '0;
            end
            default: begin
                state_s = IDLE;
                lives_s = LIVES_INIT;
                cnt_s   = '0;
            end
        endcase
        freeze_s    = (state_s == INVULN) || (state_s == GAME_OVER);
        game_over_s = (state_s == GAME_OVER);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            lives_r     <= LIVES_INIT;
            cnt_r       <= '0;
            hit_r       <= 1'b0;
            freeze_r    <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            lives_r     <= lives_s;
            cnt_r       <= cnt_s;
            hit_r       <= hit_s;
            freeze_r    <= freeze_s;
            game_over_r <= game_over_s;
        end
    end

    assign hit       = hit_r;
    assign lives     = lives_r;
    assign freeze    = freeze_r;
    assign game_over = game_over_r;

endmodule

// File: tb/tb_barrel_collision_ctl.sv
// Directed bench for barrel_collision_ctl: overlap-vector table plus
// hand-written lives / invulnerability / reset sequences.
module tb_barrel_collision_ctl;

    localparam int BARRELS     = 10;
    localparam int LIVES       = 3;
    localparam int INVULN_TIME = 100;

    logic                     clk = 1'b0;
    logic                     rst, start_game, animation;
    logic [10:0]              xpos_donkey, ypos_donkey;
    logic [BARRELS-1:0][10:0] xpos_barrel, ypos_barrel;
    logic [BARRELS-1:0]       barrel;
    logic                     hit, freeze, game_over;
    logic [1:0]               lives;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        int          slot;
        logic [10:0] xd, yd, xb, yb;
        logic        act;
        int          exp_hit;
        int          exp_lives;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    barrel_collision_ctl #(
        .BARRELS     (BARRELS),
        .LIVES       (LIVES),
        .INVULN_TIME (INVULN_TIME)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_game  (start_game),
        .animation   (animation),
        .xpos_donkey (xpos_donkey),
        .ypos_donkey (ypos_donkey),
        .xpos_barrel (xpos_barrel),
        .ypos_barrel (ypos_barrel),
        .barrel      (barrel),
        .hit         (hit),
        .lives       (lives),
        .freeze      (freeze),
        .game_over   (game_over)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_barrels();
        for (int i = 0; i < BARRELS; i++) begin
            xpos_barrel[i] = 11'd1500;
            ypos_barrel[i] = 11'd10;
        end
        barrel = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic count_hits(input int n, output int nh, output int first);
        nh    = 0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (hit) begin
                nh++;
                if (first < 0) first = i + 1;
            end
        end
    endtask

    task automatic wait_for_hit(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (hit) begin
                lat = i + 1;
                break;
            end
        end
    endtask

    initial begin
        int nh, first, lat, bad, k;
        int ht[3];
        int lh[3];

        vecs[0]  = '{"basic_overlap",      7, 11'd100,  11'd200,  11'd120,  11'd230,  1'b1, 1, 2};
        vecs[1]  = '{"x_right_touch",      7, 11'd100,  11'd200,  11'd148,  11'd200,  1'b1, 0, 3};
        vecs[2]  = '{"x_right_in",         7, 11'd100,  11'd200,  11'd147,  11'd200,  1'b1, 1, 2};
        vecs[3]  = '{"inactive_slot",      7, 11'd100,  11'd200,  11'd120,  11'd230,  1'b0, 0, 3};
        vecs[4]  = '{"x_left_touch",       2, 11'd100,  11'd200,  11'd68,   11'd200,  1'b1, 0, 3};
        vecs[5]  = '{"x_left_in",          2, 11'd100,  11'd200,  11'd69,   11'd200,  1'b1, 1, 2};
        vecs[6]  = '{"y_below_touch",      9, 11'd100,  11'd200,  11'd100,  11'd264,  1'b1, 0, 3};
        vecs[7]  = '{"y_below_in",         9, 11'd100,  11'd200,  11'd100,  11'd263,  1'b1, 1, 2};
        vecs[8]  = '{"y_above_touch",      0, 11'd100,  11'd200,  11'd100,  11'd168,  1'b1, 0, 3};
        vecs[9]  = '{"y_above_in",         0, 11'd100,  11'd200,  11'd100,  11'd169,  1'b1, 1, 2};
        vecs[10] = '{"no_wrap_2047",       5, 11'd2040, 11'd2040, 11'd2030, 11'd2030, 1'b1, 1, 2};
        vecs[11] = '{"far_apart",          4, 11'd0,    11'd0,    11'd1000, 11'd1000, 1'b1, 0, 3};

        // Reset values and idle play with no barrels.
        start_game  = 1'b1;
        animation   = 1'b0;
        xpos_donkey = 11'd100;
        ypos_donkey = 11'd200;
        clear_barrels();
        rst = 1'b1;
        tick();
        tick();
        check("reset_hit", int'(hit), 0);
        check("reset_lives", int'(lives), 3);
        check("reset_freeze", int'(freeze), 0);
        check("reset_game_over", int'(game_over), 0);
        rst = 1'b0;
        count_hits(1000, nh, first);
        check("no_barrels_hits", nh, 0);
        check("no_barrels_lives", int'(lives), 3);
        check("no_barrels_game_over", int'(game_over), 0);

        // Table of single-barrel placements.
        foreach (vecs[v]) begin
            clear_barrels();
            xpos_donkey               = vecs[v].xd;
            ypos_donkey               = vecs[v].yd;
            xpos_barrel[vecs[v].slot] = vecs[v].xb;
            ypos_barrel[vecs[v].slot] = vecs[v].yb;
            barrel[vecs[v].slot]      = vecs[v].act;
            do_reset();
            count_hits(30, nh, first);
            check({vecs[v].name, "_hits"}, nh, vecs[v].exp_hit);
            check({vecs[v].name, "_lives"}, int'(lives), vecs[v].exp_lives);
            check({vecs[v].name, "_freeze"}, int'(freeze), vecs[v].exp_hit);
            if (vecs[v].exp_hit == 1) check({vecs[v].name, "_latency_le22"}, int'(first >= 1 && first <= 22), 1);
        end

        // Continuous overlap: three spaced hits, then sticky game over.
        clear_barrels();
        xpos_donkey    = 11'd100;
        ypos_donkey    = 11'd200;
        xpos_barrel[7] = 11'd120;
        ypos_barrel[7] = 11'd230;
        barrel[7]      = 1'b1;
        do_reset();
        nh  = 0;
        bad = 0;
        k   = -1;
        for (int i = 0; i < 900; i++) begin
            tick();
            if (hit) begin
                if (nh < 3) begin
                    ht[nh] = i;
                    lh[nh] = int'(lives);
                end
                nh++;
            end
            if (game_over && k < 0) k = i;
            if (k >= 0 && (!game_over || lives != 2'd0 || !freeze)) bad++;
        end
        check("cont_hit_count", nh, 3);
        if (nh >= 3) begin
            check("cont_lives_1st", lh[0], 2);
            check("cont_lives_2nd", lh[1], 1);
            check("cont_lives_3rd", lh[2], 0);
            check("cont_gap_1_ge110", int'(ht[1] - ht[0] >= 110), 1);
            check("cont_gap_2_ge110", int'(ht[2] - ht[1] >= 110), 1);
        end
        check("cont_game_over_reached", int'(k >= 0 && k <= 400), 1);
        check("cont_game_over_sticky", bad, 0);
        check("cont_final_lives", int'(lives), 0);

        // Barrel becomes active only after a while.
        clear_barrels();
        xpos_barrel[3] = 11'd110;
        ypos_barrel[3] = 11'd210;
        do_reset();
        count_hits(100, nh, first);
        check("masked_no_hit", nh, 0);
        barrel[3] = 1'b1;
        count_hits(22, nh, first);
        check("unmasked_hit", nh, 1);
        check("unmasked_lives", int'(lives), 2);

        // Reset in the middle of the cooldown.
        do_reset();
        wait_for_hit(40, lat);
        check("pre_rst_hit_seen", int'(lat > 0), 1);
        for (int i = 0; i < 49; i++) tick();
        check("mid_invuln_freeze", int'(freeze), 1);
        rst = 1'b1;
        tick();
        check("rst_invuln_lives", int'(lives), 3);
        check("rst_invuln_freeze", int'(freeze), 0);
        check("rst_invuln_hit", int'(hit), 0);
        rst = 1'b0;

        // Intro replay while playing reloads lives.
        wait_for_hit(40, lat);
        check("anim_pre_lives", int'(lives), 2);
        barrel = '0;
        for (int i = 0; i < 110; i++) tick();
        check("cooldown_over_freeze", int'(freeze), 0);
        check("cooldown_over_lives", int'(lives), 2);
        animation = 1'b1;
        tick();
        check("anim_lives", int'(lives), 3);
        check("anim_freeze", int'(freeze), 0);
        animation = 1'b0;
        tick();

        // start_game dropped in PLAY and in INVULN.
        barrel[3] = 1'b1;
        wait_for_hit(40, lat);
        check("drop_play_pre_lives", int'(lives), 2);
        barrel = '0;
        for (int i = 0; i < 110; i++) tick();
        start_game = 1'b0;
        tick();
        check("drop_play_lives", int'(lives), 3);
        check("drop_play_freeze", int'(freeze), 0);
        check("drop_play_hit", int'(hit), 0);
        start_game = 1'b1;
        tick();
        barrel[3] = 1'b1;
        wait_for_hit(40, lat);
        check("drop_inv_pre_hit", int'(lat > 0), 1);
        for (int i = 0; i < 10; i++) tick();
        check("drop_inv_pre_freeze", int'(freeze), 1);
        start_game = 1'b0;
        tick();
        check("drop_inv_lives", int'(lives), 3);
        check("drop_inv_freeze", int'(freeze), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
